// File: rtl/ky32_fetch_pc.sv
// Program-counter and instruction-fetch sequencer for the KY32 core.
// Latency: instruction presented to decode one cycle after imem_ack; one instruction per (ack latency + 2) cycles.
// Backpressure: a single instruction is buffered; no new fetch is requested until decode takes it (if_ready).
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   pc_sel, pc_plus4      select and sequential input for the external next-PC mux
//   next_pc               mux result, loaded into the PC on advance/redirect
//   br_taken, jmp_taken, trap   single-cycle redirect pulses (trap > jump > branch)
//   imem_req/addr/ack/rdata     instruction-memory request/response
//   if_valid/ready/instr/pc     decode-side valid/ready handshake
module ky32_fetch_pc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_plus4,
  input  logic [31:0] next_pc,
  input  logic        br_taken,
  input  logic        jmp_taken,
  input  logic        trap,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [31:0] LP_STEP = 32'(PC_STEP);

  // FETCH: request outstanding; HOLD: instruction buffered for decode;
  // KILL: a redirect arrived while a request was in flight, drain it.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_d;
  logic [31:0] r_pc_q;
  logic [31:0] w_pc_d;
  logic [31:0] r_redir_q;
  logic [31:0] w_redir_d;
  logic        r_if_valid;
  logic        w_if_valid_d;
  logic [31:0] r_if_instr;
  logic [31:0] w_if_instr_d;
  logic [31:0] r_if_pc;
  logic [31:0] w_if_pc_d;
  logic        w_redirect;

  assign w_redirect = trap | jmp_taken | br_taken;
  assign pc_plus4   = r_pc_q + LP_STEP;
  assign imem_addr  = r_pc_q;
  assign if_valid   = r_if_valid;
  assign if_instr   = r_if_instr;
  assign if_pc      = r_if_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_pc_q     <= RESET_VECTOR;
      r_redir_q  <= 32'h0;
      r_if_valid <= 1'b0;
      r_if_instr <= 32'h0;
      r_if_pc    <= 32'h0;
    end else begin
      r_state    <= w_state_d;
      r_pc_q     <= w_pc_d;
      r_redir_q  <= w_redir_d;
      r_if_valid <= w_if_valid_d;
      r_if_instr <= w_if_instr_d;
      r_if_pc    <= w_if_pc_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc_q;
    w_redir_d    = r_redir_q;
    w_if_valid_d = r_if_valid;
    w_if_instr_d = r_if_instr;
    w_if_pc_d    = r_if_pc;

    if (trap)           pc_sel = 2'b11;
    else if (jmp_taken) pc_sel = 2'b10;
    else if (br_taken)  pc_sel = 2'b01;
    else                pc_sel = 2'b00;

    // The request is held (with a frozen address) until acked, so it is
    // only dropped while an instruction is buffered or during reset.
    imem_req = !rst && (r_state != ST_HOLD);

    case (r_state)
      ST_FETCH: begin
        if (imem_ack) begin
          // With no redirect pc_sel is 00, so next_pc is the sequential PC.
          w_pc_d = next_pc;
          if (!w_redirect) begin
            w_if_instr_d = imem_rdata;
            w_if_pc_d    = r_pc_q;
            w_if_valid_d = 1'b1;
            w_state_d    = ST_HOLD;
          end
        end else if (w_redirect) begin
          w_redir_d = next_pc;
          w_state_d = ST_KILL;
        end
      end
      ST_HOLD: begin
        if (w_redirect) begin
          // Flush the buffered instruction even if decode is taking it.
          w_if_valid_d = 1'b0;
          w_pc_d       = next_pc;
          w_state_d    = ST_FETCH;
        end else if (if_ready) begin
          w_if_valid_d = 1'b0;
          w_state_d    = ST_FETCH;
        end
      end
      ST_KILL: begin
        if (w_redirect) w_redir_d = next_pc;
        if (imem_ack) begin
          // A redirect coinciding with the drain ack is the newest target.
          w_pc_d    = w_redirect ? next_pc : r_redir_q;
          w_state_d = ST_FETCH;
        end
      end
      default: w_state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_ky32_fetch_pc.sv
module tb_ky32_fetch_pc;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        br_taken;
  logic        jmp_taken;
  logic        trap;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  ky32_fetch_pc #(.RESET_VECTOR(RV), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .pc_sel(pc_sel), .pc_plus4(pc_plus4), .next_pc(next_pc),
    .br_taken(br_taken), .jmp_taken(jmp_taken), .trap(trap),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment targets for the external next-PC mux.
  logic [31:0] br_tgt, jmp_tgt, trap_vec;

  // Reference model: a fetcher either owns a buffered instruction or is
  // fetching from m_pc; an in-flight fetch may be marked stale, in which
  // case its data is dropped and fetching resumes at m_resume.
  logic [31:0] m_pc;
  logic        m_have_instr;
  logic [31:0] m_instr;
  logic [31:0] m_instr_pc;
  logic        m_stale;
  logic [31:0] m_resume;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_have_instr = 1'b0; m_instr = 32'h0; m_instr_pc = 32'h0;
    m_stale = 1'b0; m_resume = 32'h0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // advance the model at the rising edge.
  task automatic step(input logic r, input logic b, input logic j, input logic t,
                      input logic a, input logic [31:0] d, input logic rdy);
    logic [1:0]  exp_sel;
    logic [31:0] tgt;
    logic        redir;
    rst = r; br_taken = b; jmp_taken = j; trap = t;
    imem_ack = a; imem_rdata = d; if_ready = rdy;
    redir = t | j | b;
    if (t)      begin exp_sel = 2'b11; tgt = trap_vec; end
    else if (j) begin exp_sel = 2'b10; tgt = jmp_tgt;  end
    else if (b) begin exp_sel = 2'b01; tgt = br_tgt;   end
    else        begin exp_sel = 2'b00; tgt = m_pc + 32'd4; end
    next_pc = tgt;
    @(negedge clk);
    chk("pc_sel",    {30'h0, pc_sel}, {30'h0, exp_sel});
    chk("pc_plus4",  pc_plus4, m_pc + 32'd4);
    chk("imem_req",  {31'h0, imem_req}, {31'h0, (!r && !m_have_instr)});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid",  {31'h0, if_valid}, {31'h0, m_have_instr});
    chk("if_instr",  if_instr, m_instr);
    chk("if_pc",     if_pc, m_instr_pc);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (!m_have_instr) begin
      if (a) begin
        if (redir) begin
          m_pc = tgt; m_stale = 1'b0;
        end else if (m_stale) begin
          m_pc = m_resume; m_stale = 1'b0;
        end else begin
          m_instr = d; m_instr_pc = m_pc; m_have_instr = 1'b1; m_pc = tgt;
        end
      end else if (redir) begin
        m_stale = 1'b1; m_resume = tgt;
      end
    end else begin
      if (redir) begin
        m_have_instr = 1'b0; m_pc = tgt;
      end else if (rdy) begin
        m_have_instr = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; br_taken = 0; jmp_taken = 0; trap = 0; imem_ack = 0;
    imem_rdata = 0; if_ready = 0; next_pc = 0;
    br_tgt = 32'h200; jmp_tgt = 32'h40; trap_vec = 32'h100;
    model_reset();
    @(posedge clk); #1;

    // Reset held: no request.
    for (int i = 0; i < 3; i++) step(1, 0,0,0, 0, 32'h0, 0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);

    // Sequential fetch 0x0 with a 5-cycle decode stall, then 0x4, 0x8.
    step(0, 0,0,0, 0, 32'h0, 1);
    step(0, 0,0,0, 1, 32'hA000_0000, 1);
    chk("seq_pc0", if_pc, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0,0,0, 1, 32'h1234_5678, 0);
    chk("hold_instr", if_instr, 32'hA000_0000);
    step(0, 0,0,0, 0, 32'h0, 1);
    chk("after_hold_addr", imem_addr, 32'h4);
    step(0, 0,0,0, 0, 32'h0, 1);
    step(0, 0,0,0, 1, 32'hA000_0004, 1);
    chk("seq_pc1", if_pc, 32'h4);
    step(0, 0,0,0, 0, 32'h0, 1);
    step(0, 0,0,0, 0, 32'h0, 1);
    step(0, 0,0,0, 1, 32'hA000_0008, 1);
    chk("seq_pc2", if_pc, 32'h8);
    step(0, 0,0,0, 0, 32'h0, 1);

    // Branch while request outstanding: kill, drop DEADBEEF, resume at 0x200.
    step(0, 1,0,0, 0, 32'h0, 1);
    step(0, 0,0,0, 0, 32'h0, 1);
    chk("kill_addr", imem_addr, 32'hC);
    step(0, 0,0,0, 1, 32'hDEAD_BEEF, 1);
    chk("kill_drop_valid", {31'h0, if_valid}, 32'h0);
    chk("kill_resume", imem_addr, 32'h200);

    // Fetch at 0x200, then trap+branch while holding: flush, go to 0x100.
    step(0, 0,0,0, 1, 32'hB000_0200, 0);
    step(0, 1,0,1, 0, 32'h0, 1);
    chk("trap_flush", {31'h0, if_valid}, 32'h0);
    chk("trap_addr", imem_addr, 32'h100);

    // Jump coincident with ack: no kill cycle, next request at 0x40.
    step(0, 0,1,0, 1, 32'hBAD0_0001, 1);
    chk("jmp_ack_addr", imem_addr, 32'h40);
    chk("jmp_ack_req", {31'h0, imem_req}, 32'h1);
    // Redirect in KILL with ack the same cycle: latest target (0x300) wins.
    br_tgt = 32'h80; jmp_tgt = 32'h300;
    step(0, 1,0,0, 0, 32'h0, 1);
    step(0, 0,1,0, 1, 32'hBAD0_0002, 1);
    chk("kill_latest", imem_addr, 32'h300);

    // Wrap-around at the top of the address space.
    jmp_tgt = 32'hFFFF_FFFC;
    step(0, 0,1,0, 1, 32'hBAD0_0003, 1);
    chk("wrap_plus4", pc_plus4, 32'h0);
    step(0, 0,0,0, 1, 32'hC000_FFFC, 0);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    step(0, 0,0,0, 0, 32'h0, 1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset during KILL.
    br_tgt = 32'h500;
    step(0, 1,0,0, 0, 32'h0, 1);
    step(1, 0,0,0, 1, 32'hEEEE_EEEE, 1);
    chk("rst_kill_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_kill_pc", if_pc, 32'h0);
    step(0, 0,0,0, 0, 32'h0, 1);
    chk("rst_kill_addr", imem_addr, RV);

    // Randomized traffic, including unaligned targets and stray acks.
    for (int i = 0; i < 1500; i++) begin
      logic r, b, j, t;
      br_tgt = $urandom; jmp_tgt = $urandom; trap_vec = $urandom;
      r = ($urandom_range(0, 99) == 0);
      b = ($urandom_range(0, 15) == 0);
      j = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 31) == 0);
      step(r, b, j, t, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ky32_fetch_pc.md
Name: ky32_fetch_pc

Overview:
- Program-counter and instruction-fetch sequencer for the KY32 core.
- Sits directly upstream of the next-PC KY32_mux4x32:
  - drives that mux's 2-bit select and its "a" input (PC+4);
  - consumes the mux output as next_pc.
- Issues instruction-memory requests and presents one fetched instruction at a time to decode over a valid/ready handshake.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_sel  out  2  select to next-PC mux4x32: 00 = pc_plus4, 01 = branch target, 10 = jump target, 11 = trap vector.
- pc_plus4  out  32  pc_q + PC_STEP (mod 2^32); feeds mux input a.
- next_pc  in  32  output of the next-PC mux.
- br_taken  in  1  single-cycle branch redirect pulse from execute.
- jmp_taken  in  1  single-cycle jump redirect pulse.
- trap  in  1  single-cycle trap redirect pulse.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address; equals pc_q.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- if_valid  out  1  if_instr/if_pc valid to decode.
- if_ready  in  1  decode accepts this cycle.
- if_instr  out  32  instruction word.
- if_pc  out  32  address of if_instr.

Behaviour:
- Registers:
  - pc_q: current fetch address.
  - redir_q: pending redirect target.
  - state in {FETCH, HOLD, KILL}.
  - Output registers if_valid, if_instr, if_pc.
- Reset (rst=1 at edge):
  - pc_q=RESET_VECTOR, state=FETCH, if_valid=0, if_instr=0, if_pc=0, redir_q=0.
  - imem_req is 0 while rst is high.
  - First request is issued in the first cycle after rst deasserts.
  - rst overrides every other event, including mid-fetch.
- pc_sel (combinational, every cycle), priority trap > jmp_taken > br_taken:
  - trap → 11, else jmp_taken → 10, else br_taken → 01, else 00.
- redirect = trap | jmp_taken | br_taken.
- Memory protocol:
  - imem_req is high only in FETCH and KILL, and stays high until imem_ack.
  - imem_addr is stable while imem_req is high.
  - imem_ack is ignored when imem_req=0.
- FETCH:
  - ack and no redirect: if_instr<=imem_rdata, if_pc<=pc_q, if_valid<=1, pc_q<=next_pc (pc_sel=00, so pc+4), go HOLD.
  - ack with redirect: discard rdata, pc_q<=next_pc, stay FETCH, if_valid stays 0.
  - no ack, redirect: redir_q<=next_pc, go KILL.
  - no ack, no redirect: stay.
- HOLD (if_valid=1, imem_req=0):
  - redirect: if_valid<=0 (flush, even if if_ready), pc_q<=next_pc, go FETCH.
  - else if_ready: if_valid<=0, go FETCH; the next request is raised the following cycle.
  - else hold all outputs stable.
- KILL (outstanding request must be drained):
  - imem_addr keeps the old pc_q.
  - redirect in KILL: redir_q<=next_pc (latest wins).
  - On ack: rdata discarded; pc_q<=(redirect ? next_pc : redir_q); go FETCH.
- Buffering rules:
  - if_valid is never set in KILL.
  - At most one instruction is buffered.
- Arithmetic:
  - pc_plus4 wraps: 32'hFFFF_FFFC → 32'h0000_0000.
  - No alignment check; next_pc is taken verbatim.
- Latency:
  - Minimum request-to-if_valid is 1 cycle after ack.
  - Steady-state throughput is one instruction per (ack latency + 2) cycles with if_ready held high.

Test Plan:
- Reset then ack every request 1 cycle after req, if_ready=1 → if_pc sequence 0x0, 0x4, 0x8; pc_sel=00 throughout; imem_req=0 during rst.
- HOLD with if_ready=0 for 5 cycles → if_valid, if_instr, if_pc stable; imem_req=0; no pc change; then if_ready=1 → next req at addr 0x4.
- br_taken pulse in FETCH with no ack, next_pc=0x200 → KILL, imem_addr stays old pc; ack with rdata 0xDEAD_BEEF is dropped (if_valid stays 0); next req addr=0x200.
- trap and br_taken both asserted in HOLD → pc_sel=11; if_valid cleared; next req addr = value on next_pc (trap vector 0x100).
- Redirect coincident with ack in FETCH, next_pc=0x40 → rdata dropped, next req at 0x40 with no KILL cycle; redirect in KILL with ack same cycle → latest next_pc used.
- pc_q=0xFFFF_FFFC acked → pc_plus4=0 and next req addr 0x0; assert rst during KILL → all outputs at reset values and the first req at RESET_VECTOR.
